instr_fetch: RTL and testbench



---
 rtl/instr_fetch.sv | 163 ++++++++++++++++
 tb/tb_instr_fetch.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: holds the fetch PC, issues word requests to
// instruction memory over a valid/ready handshake, and buffers the in-order
// responses in a DEPTH-entry FIFO that feeds decode.
// A redirect (taken branch/jump) reloads the PC, empties the FIFO, and marks
// every still-outstanding response to be dropped when it returns.
//
// Optional feature macro: INSTR_FETCH_BYPASS_EN
//   When defined, a response that arrives while the FIFO is empty and nothing
//   is pending drop is forwarded combinationally to decode. This gives a
//   1-cycle fetch latency. Without it, instr/instr_pc are always registered.

module instr_fetch #(
    parameter int                 D_WIDTH  = 32,
    parameter logic [D_WIDTH-1:0] RESET_PC = '0,
    parameter int                 DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [D_WIDTH-1:0] imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [D_WIDTH-1:0] imem_rsp_data,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [D_WIDTH-1:0] instr,
    output logic [D_WIDTH-1:0] instr_pc,
    input  logic               redirect,
    input  logic [D_WIDTH-1:0] redirect_target
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [D_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]      outst_q, outst_d;
    logic [CW-1:0]      drop_q, drop_d;
    logic [CW-1:0]      count_q, count_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [D_WIDTH-1:0] fifo_pc_q   [DEPTH];
    logic [D_WIDTH-1:0] fifo_pc_d   [DEPTH];
    logic [D_WIDTH-1:0] fifo_data_q [DEPTH];
    logic [D_WIDTH-1:0] fifo_data_d [DEPTH];
    logic               started_q, started_d;

    logic               rsp_fire;
    logic               rsp_keep;
    logic               accept;
    logic               push;
    logic               pop;
    logic               fifo_valid;
    logic [CW:0]        credit_sum;
    logic [D_WIDTH-1:0] rsp_pc;
`ifdef INSTR_FETCH_BYPASS_EN
    logic               bypass;
`endif

    // Request side: credits count both in-flight requests and buffered words;
    // a pop only frees a credit once count_q has updated (next cycle).
    always_comb begin
        credit_sum     = {1'b0, outst_q} + {1'b0, count_q};
        imem_req_valid = started_q && !redirect && (credit_sum < (CW+1)'(DEPTH));
        imem_req_addr  = fetch_pc_q;
        accept         = imem_req_valid && imem_req_ready;
    end

    // Response side. When nothing is pending drop, every outstanding request
    // belongs to the current stream and they are consecutive words ending just
    // below fetch_pc, so the oldest one's PC is fetch_pc - 4*outstanding.
    always_comb begin
        rsp_fire   = imem_rsp_valid && (outst_q != '0);
        rsp_keep   = rsp_fire && (drop_q == '0) && !redirect;
        rsp_pc     = fetch_pc_q - (D_WIDTH'(outst_q) << 2);
        fifo_valid = (count_q != '0);
    end

    // Decode-facing output mux and FIFO push/pop qualification.
`ifdef INSTR_FETCH_BYPASS_EN
    always_comb begin
        bypass      = rsp_keep && !fifo_valid;
        instr_valid = bypass || (fifo_valid && !redirect);
        instr       = bypass ? imem_rsp_data : fifo_data_q[rd_ptr_q];
        instr_pc    = bypass ? rsp_pc        : fifo_pc_q[rd_ptr_q];
        pop         = fifo_valid && !redirect && instr_ready;
        push        = rsp_keep && !(bypass && instr_ready);
    end
`else
    always_comb begin
        instr_valid = fifo_valid && !redirect;
        instr       = fifo_data_q[rd_ptr_q];
        instr_pc    = fifo_pc_q[rd_ptr_q];
        pop         = instr_valid && instr_ready;
        push        = rsp_keep;
    end
`endif

    // Next-state logic; redirect overrides everything else in the cycle.
    always_comb begin
        started_d   = 1'b1;
        fetch_pc_d  = fetch_pc_q;
        outst_d     = outst_q;
        drop_d      = drop_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        fifo_pc_d   = fifo_pc_q;
        fifo_data_d = fifo_data_q;
        if (redirect) begin
            fetch_pc_d = redirect_target & ~D_WIDTH'(3);
            outst_d    = outst_q - CW'(rsp_fire);
            drop_d     = outst_q - CW'(rsp_fire);
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + D_WIDTH'(4);
            end
            outst_d = outst_q + CW'(accept) - CW'(rsp_fire);
            if (rsp_fire && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
            if (push) begin
                fifo_pc_d[wr_ptr_q]   = rsp_pc;
                fifo_data_d[wr_ptr_q] = imem_rsp_data;
                wr_ptr_d              = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started_q  <= 1'b0;
            fetch_pc_q <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc_q[i]   <= '0;
                fifo_data_q[i] <= '0;
            end
        end else begin
            started_q   <= started_d;
            fetch_pc_q  <= fetch_pc_d;
            outst_q     <= outst_d;
            drop_q      <= drop_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            fifo_pc_q   <= fifo_pc_d;
            fifo_data_q <= fifo_data_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a behavioural memory with random response delay,
// an event recorder, and scenario tasks that compare the recorded request
// and decode streams against the expected PC arithmetic.

module tb_instr_fetch;

    localparam int          W        = 32;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;
    localparam int          DEPTH    = 2;
`ifdef INSTR_FETCH_BYPASS_EN
    localparam int          EXP_LAT  = 1;
`else
    localparam int          EXP_LAT  = 2;
`endif
    localparam int K_RDR = 0;
    localparam int K_ACC = 1;
    localparam int K_POP = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          imem_req_valid;
    logic          imem_req_ready = 1'b0;
    logic [W-1:0]  imem_req_addr;
    logic          imem_rsp_valid = 1'b0;
    logic [W-1:0]  imem_rsp_data = '0;
    logic          instr_valid;
    logic          instr_ready = 1'b0;
    logic [W-1:0]  instr;
    logic [W-1:0]  instr_pc;
    logic          redirect = 1'b0;
    logic [W-1:0]  redirect_target = '0;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] a;
        logic [31:0] d;
    } ev_t;
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    ev_t   evq[$];
    mreq_t mem_q[$];
    int    cyc = 0;
    int    last_due = 0;
    int    rsp_total = 0;
    int    mem_dmin = 1;
    int    mem_dmax = 1;
    bit    mem_toggle = 1'b0;
    logic  mem_rv_nxt = 1'b0;
    logic  mem_rdy_nxt = 1'b0;
    logic [31:0] mem_rd_nxt = '0;

    instr_fetch #(.D_WIDTH(W), .RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .redirect        (redirect),
        .redirect_target (redirect_target)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    // Recorder and memory model: observe the handshakes of the current cycle
    // mid-cycle, then decide what the memory presents next cycle.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            mem_q.delete();
            mem_rv_nxt  = 1'b0;
            mem_rdy_nxt = 1'b0;
            mem_rd_nxt  = '0;
            last_due    = 0;
        end else begin
            if (redirect)
                evq.push_back('{K_RDR, cyc, redirect_target, 32'h0});
            if (instr_valid && instr_ready)
                evq.push_back('{K_POP, cyc, instr_pc, instr});
            if (imem_rsp_valid && mem_q.size() > 0) begin
                void'(mem_q.pop_front());
                rsp_total++;
            end
            if (imem_req_valid && imem_req_ready) begin
                int due;
                evq.push_back('{K_ACC, cyc, imem_req_addr, 32'h0});
                due = cyc + int'($urandom_range(mem_dmax, mem_dmin));
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                mem_q.push_back('{imem_req_addr, due});
            end
            mem_rv_nxt  = (mem_q.size() > 0) && (mem_q[0].due <= cyc + 1);
            mem_rd_nxt  = mem_rv_nxt ? mem_word(mem_q[0].addr) : 32'h0;
            mem_rdy_nxt = mem_toggle ? ~imem_req_ready : 1'b1;
        end
    end

    always @(posedge clk) begin
        #1;
        imem_req_ready = mem_rdy_nxt;
        imem_rsp_valid = mem_rv_nxt;
        imem_rsp_data  = mem_rd_nxt;
    end

    task automatic do_reset();
        rst_n           = 1'b0;
        redirect        = 1'b0;
        redirect_target = '0;
        instr_ready     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        evq.delete();
        rsp_total = 0;
        rst_n     = 1'b1;
    endtask

    task automatic test_reset();
        bit found = 0;
        mem_toggle = 0; mem_dmin = 1; mem_dmax = 1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
        n_checks++; if (imem_req_addr !== RST_PC) begin n_fail++; $display("FAIL rst_req_addr: got %h want %h", imem_req_addr, RST_PC); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_instr_valid: got %b want 0", instr_valid); end
        n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %h want 0", instr); end
        n_checks++; if (instr_pc !== 32'h0) begin n_fail++; $display("FAIL rst_instr_pc: got %h want 0", instr_pc); end
        rst_n = 1'b1;
        for (int i = 0; i < 4 && !found; i++) begin
            @(negedge clk); #1;
            if (imem_req_valid === 1'b1) found = 1;
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL rst_first_req: got no request want request within 4 cycles"); end
        n_checks++; if (imem_req_addr !== RST_PC) begin n_fail++; $display("FAIL rst_first_addr: got %h want %h", imem_req_addr, RST_PC); end
    endtask

    task automatic test_sequential();
        logic [31:0] ea = RST_PC, ep = RST_PC;
        int na = 0, np = 0, fa = -1, fp = -1;
        mem_toggle = 0; mem_dmin = 1; mem_dmax = 1;
        do_reset();
        instr_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        foreach (evq[i]) begin
            if (evq[i].kind == K_ACC) begin
                if (fa < 0) fa = evq[i].cyc;
                n_checks++;
                if (evq[i].a !== ea) begin n_fail++; $display("FAIL seq_addr: got %h want %h", evq[i].a, ea); end
                ea += 4; na++;
            end else if (evq[i].kind == K_POP) begin
                if (fp < 0) fp = evq[i].cyc;
                n_checks++;
                if (evq[i].a !== ep || evq[i].d !== mem_word(ep)) begin
                    n_fail++; $display("FAIL seq_pop: got pc %h instr %h want pc %h instr %h", evq[i].a, evq[i].d, ep, mem_word(ep));
                end
                ep += 4; np++;
            end
        end
        n_checks++; if (na < 3) begin n_fail++; $display("FAIL seq_req_count: got %0d want >=3", na); end
        n_checks++; if (np < 3) begin n_fail++; $display("FAIL seq_pop_count: got %0d want >=3", np); end
        n_checks++; if (fp - fa != EXP_LAT) begin n_fail++; $display("FAIL seq_latency: got %0d want %0d", fp - fa, EXP_LAT); end
    endtask

    task automatic test_backpressure();
        int na = 0;
        mem_toggle = 0; mem_dmin = 1; mem_dmax = 1;
        do_reset();
        repeat (12) @(negedge clk);
        #1;
        foreach (evq[i]) if (evq[i].kind == K_ACC) na++;
        n_checks++; if (na != DEPTH) begin n_fail++; $display("FAIL bp_outstanding: got %0d want %0d", na, DEPTH); end
        n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_req_stalled: got %b want 0", imem_req_valid); end
        n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL bp_instr_valid: got %b want 1", instr_valid); end
        @(posedge clk); #1; instr_ready = 1'b1;
        @(negedge clk); #1;
        n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_same_cycle_credit: got %b want 0", imem_req_valid); end
        n_checks++; if (instr_pc !== RST_PC) begin n_fail++; $display("FAIL bp_head_pc: got %h want %h", instr_pc, RST_PC); end
        @(posedge clk); #1; instr_ready = 1'b0;
        @(negedge clk); #1;
        n_checks++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL bp_credit_return: got %b want 1", imem_req_valid); end
        n_checks++; if (imem_req_addr !== RST_PC + 32'd8) begin n_fail++; $display("FAIL bp_next_addr: got %h want %h", imem_req_addr, RST_PC + 32'd8); end
    endtask

    task automatic test_redirect_inflight();
        bit found = 0;
        int r = -1, np = 0, pre_pops = 0;
        logic [31:0] first_acc = 32'hFFFF_FFFF;
        bit got_acc = 0;
        mem_toggle = 0; mem_dmin = 3; mem_dmax = 3;
        do_reset();
        instr_ready = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk); #1;
            if (mem_q.size() == 2) found = 1;
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL rdr_setup: got no 2 in flight want 2 in flight within 20 cycles"); end
        @(posedge clk); #1;
        redirect = 1'b1; redirect_target = 32'h100;
        @(negedge clk); #1;
        n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rdr_req_suppressed: got %b want 0", imem_req_valid); end
        @(posedge clk); #1;
        redirect = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        foreach (evq[i]) if (evq[i].kind == K_RDR && r < 0) r = i;
        for (int i = 0; i < evq.size(); i++) begin
            if (i < r && evq[i].kind == K_POP) pre_pops++;
            if (i > r && evq[i].kind == K_ACC && !got_acc) begin first_acc = evq[i].a; got_acc = 1; end
            if (i > r && evq[i].kind == K_POP && np < 2) begin
                n_checks++;
                if (evq[i].a !== 32'h100 + 32'(4 * np) || evq[i].d !== mem_word(32'h100 + 32'(4 * np))) begin
                    n_fail++; $display("FAIL rdr_pop%0d: got pc %h instr %h want pc %h instr %h", np, evq[i].a, evq[i].d,
                                       32'h100 + 32'(4 * np), mem_word(32'h100 + 32'(4 * np)));
                end
                np++;
            end
        end
        n_checks++; if (pre_pops != 0) begin n_fail++; $display("FAIL rdr_pre_pops: got %0d want 0", pre_pops); end
        n_checks++; if (first_acc !== 32'h100) begin n_fail++; $display("FAIL rdr_first_addr: got %h want 00000100", first_acc); end
        n_checks++; if (np != 2) begin n_fail++; $display("FAIL rdr_pop_count: got %0d want 2", np); end
    endtask

    task automatic test_redirect_hold();
        @(posedge clk); #1;
        redirect = 1'b1; redirect_target = 32'h103;
        @(negedge clk); #1;
        n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL hold_req0: got %b want 0", imem_req_valid); end
        @(posedge clk); #1; redirect_target = 32'h203;
        @(negedge clk); #1;
        n_checks++; if (imem_req_addr !== 32'h100) begin n_fail++; $display("FAIL hold_align: got %h want 00000100", imem_req_addr); end
        n_checks++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
            n_fail++; $display("FAIL hold_quiet: got req %b instr %b want 0 0", imem_req_valid, instr_valid);
        end
        @(posedge clk); #1; redirect_target = 32'h307;
        @(negedge clk); #1;
        n_checks++; if (imem_req_addr !== 32'h200) begin n_fail++; $display("FAIL hold_reload: got %h want 00000200", imem_req_addr); end
        @(posedge clk); #1; redirect = 1'b0;
        @(negedge clk); #1;
        n_checks++; if (imem_req_addr !== 32'h304) begin n_fail++; $display("FAIL hold_final: got %h want 00000304", imem_req_addr); end
    endtask

    task automatic test_redirect_collision();
        bit found = 0, got_pop = 0;
        int r = -1;
        logic [31:0] first_pop = 32'hFFFF_FFFF;
        mem_toggle = 0; mem_dmin = 2; mem_dmax = 2;
        do_reset();
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk); #1;
            if (rsp_total == 1 && mem_q.size() == 1 && mem_rv_nxt) found = 1;
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL col_setup: got no collision slot want one within 20 cycles"); end
        @(posedge clk); #1;
        redirect = 1'b1; redirect_target = 32'h200; instr_ready = 1'b1;
        @(negedge clk); #1;
        n_checks++; if (imem_rsp_valid !== 1'b1 || instr_valid !== 1'b0) begin
            n_fail++; $display("FAIL col_cycle: got rsp %b instr_valid %b want 1 0", imem_rsp_valid, instr_valid);
        end
        @(posedge clk); #1; redirect = 1'b0;
        @(negedge clk); #1;
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL col_flushed: got %b want 0", instr_valid); end
        n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
            n_fail++; $display("FAIL col_restart: got req %b addr %h want 1 00000200", imem_req_valid, imem_req_addr);
        end
        repeat (10) @(posedge clk);
        #1;
        foreach (evq[i]) if (evq[i].kind == K_RDR && r < 0) r = i;
        for (int i = r + 1; i < evq.size(); i++)
            if (evq[i].kind == K_POP && !got_pop) begin first_pop = evq[i].a; got_pop = 1; end
        n_checks++; if (first_pop !== 32'h200) begin n_fail++; $display("FAIL col_first_pop: got %h want 00000200", first_pop); end
    endtask

    task automatic test_reset_midop();
        bit got_acc = 0, got_pop = 0;
        logic [31:0] fa = 32'hFFFF_FFFF, fp = 32'hFFFF_FFFF;
        mem_toggle = 0; mem_dmin = 1; mem_dmax = 2;
        do_reset();
        instr_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_valids: got req %b instr %b want 0 0", imem_req_valid, instr_valid);
        end
        n_checks++; if (imem_req_addr !== RST_PC || instr !== 32'h0 || instr_pc !== 32'h0) begin
            n_fail++; $display("FAIL midrst_values: got addr %h instr %h pc %h want %h 0 0", imem_req_addr, instr, instr_pc, RST_PC);
        end
        do_reset();
        instr_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        foreach (evq[i]) begin
            if (evq[i].kind == K_ACC && !got_acc) begin fa = evq[i].a; got_acc = 1; end
            if (evq[i].kind == K_POP && !got_pop) begin fp = evq[i].a; got_pop = 1; end
        end
        n_checks++; if (fa !== RST_PC || fp !== RST_PC) begin
            n_fail++; $display("FAIL midrst_restart: got addr %h pc %h want %h %h", fa, fp, RST_PC, RST_PC);
        end
    endtask

    task automatic test_random();
        logic [31:0] ea = RST_PC, ep = RST_PC;
        int hold = 0, np = 0;
        mem_toggle = 1; mem_dmin = 1; mem_dmax = 3;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            instr_ready = ($urandom_range(0, 3) != 0);
            if (hold > 0) begin
                hold--;
                redirect_target = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            end else if ($urandom_range(0, 29) == 0) begin
                redirect = 1'b1;
                hold = int'($urandom_range(0, 2));
                redirect_target = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            end else begin
                redirect = 1'b0;
            end
        end
        redirect = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        foreach (evq[i]) begin
            if (evq[i].kind == K_RDR) begin
                ea = {evq[i].a[31:2], 2'b00};
                ep = {evq[i].a[31:2], 2'b00};
            end else if (evq[i].kind == K_ACC) begin
                n_checks++;
                if (evq[i].a !== ea) begin n_fail++; $display("FAIL rnd_addr: got %h want %h at cycle %0d", evq[i].a, ea, evq[i].cyc); end
                ea += 4;
            end else begin
                n_checks++;
                if (evq[i].a !== ep || evq[i].d !== mem_word(ep)) begin
                    n_fail++; $display("FAIL rnd_pop: got pc %h instr %h want pc %h instr %h at cycle %0d",
                                       evq[i].a, evq[i].d, ep, mem_word(ep), evq[i].cyc);
                end
                ep += 4; np++;
            end
        end
        n_checks++; if (np < 100) begin n_fail++; $display("FAIL rnd_progress: got %0d pops want >=100", np); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_hold();
        test_redirect_collision();
        test_reset_midop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
